// File: rtl/sram_burst_pkg.sv
// Shared types and default sizing for the SRAM burst master.
package sram_burst_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_CAP,
    RD_RESP
  } state_t;

endpackage

// File: rtl/sram_burst_master_if.sv
// Command, write-data, read-data, status and SRAM-side signals of the burst master.
interface sram_burst_master_if #(
  parameter int addr_width = sram_burst_pkg::DEF_ADDR_W,
  parameter int data_width = sram_burst_pkg::DEF_DATA_W
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [addr_width-1:0] cmd_addr;
  logic [addr_width-1:0] cmd_len;

  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [data_width-1:0] wdata;

  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [data_width-1:0] rdata;

  logic                  busy;

  logic                  mem_wr;
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_din;
  logic [data_width-1:0] mem_dout;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  wdata_valid, wdata, rdata_ready, mem_dout,
    output cmd_ready, wdata_ready, rdata_valid, rdata, busy,
    output mem_wr, mem_addr, mem_din
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output wdata_valid, wdata, rdata_ready, mem_dout,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, busy,
    input  mem_wr, mem_addr, mem_din
  );

endinterface

// File: rtl/sram_addr_gen.sv
// Burst address/beat counter: load start address and beats-minus-one, step per beat.
module sram_addr_gen #(
  parameter int addr_width = sram_burst_pkg::DEF_ADDR_W,
  parameter int depth      = sram_burst_pkg::DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [addr_width-1:0] load_addr,
  input  logic [addr_width-1:0] load_len,
  output logic [addr_width-1:0] addr,
  output logic                  last
);

  localparam logic [addr_width-1:0] ADDR_MAX = addr_width'(depth - 1);

  logic [addr_width-1:0] cnt;

  // Explicit wrap keeps non-power-of-two depths in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= load_addr;
      cnt  <= load_len;
    end else if (step) begin
      addr <= (addr == ADDR_MAX) ? '0 : addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/sram_burst_master.sv
// Burst master turning write/read burst commands into single-port SRAM accesses.
module sram_burst_master
  import sram_burst_pkg::*;
#(
  parameter int addr_width = DEF_ADDR_W,
  parameter int data_width = DEF_DATA_W,
  parameter int depth      = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  sram_burst_master_if.master bus
);

  state_t                state, next;
  logic                  load, step, last;
  logic [addr_width-1:0] addr, addr_hold, mem_addr_c;
  logic [data_width-1:0] rdata_q, mem_din_c;
  logic                  cmd_ready_c, wdata_ready_c, rdata_valid_c, mem_wr_c;

  sram_addr_gen #(
    .addr_width(addr_width),
    .depth     (depth)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .load_addr(bus.cmd_addr),
    .load_len (bus.cmd_len),
    .addr     (addr),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdata_q   <= '0;
      addr_hold <= '0;
    end else begin
      state <= next;
      if (state == RD_CAP) rdata_q <= bus.mem_dout;
      // Remember the last presented address so IDLE keeps it on the bus.
      if (state == WRITE || state == RD_ADDR) addr_hold <= addr;
    end
  end

  // Handshake outputs are gated by rst so a mid-burst reset issues no more writes.
  always_comb begin
    next          = state;
    load          = 1'b0;
    step          = 1'b0;
    cmd_ready_c   = 1'b0;
    wdata_ready_c = 1'b0;
    rdata_valid_c = 1'b0;
    mem_wr_c      = 1'b0;
    mem_addr_c    = addr_hold;
    mem_din_c     = '0;
    case (state)
      IDLE: begin
        cmd_ready_c = !rst;
        if (bus.cmd_valid && !rst) begin
          load = 1'b1;
          next = bus.cmd_wr ? WRITE : RD_ADDR;
        end
      end
      WRITE: begin
        wdata_ready_c = !rst;
        mem_wr_c      = bus.wdata_valid && !rst;
        mem_addr_c    = addr;
        mem_din_c     = bus.wdata;
        if (mem_wr_c) begin
          step = 1'b1;
          if (last) next = IDLE;
        end
      end
      RD_ADDR: begin
        mem_addr_c = addr;
        next       = RD_CAP;
      end
      RD_CAP: next = RD_RESP;
      RD_RESP: begin
        rdata_valid_c = !rst;
        if (bus.rdata_ready && !rst) begin
          step = 1'b1;
          next = last ? IDLE : RD_ADDR;
        end
      end
      default: next = IDLE;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.wdata_ready = wdata_ready_c;
  assign bus.rdata_valid = rdata_valid_c;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = (state != IDLE);
  assign bus.mem_wr      = mem_wr_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_din     = mem_din_c;

endmodule

// File: tb/tb_sram_burst_master.sv
// Randomized bench for sram_burst_master against an array reference of SRAM contents.
module tb_sram_burst_master;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_burst_master_if #(.addr_width(AW), .data_width(DW)) bus ();

  sram_burst_master #(.addr_width(AW), .data_width(DW), .depth(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf    [DEPTH];
  int nvec = 0, nerr = 0, wr_cnt = 0;

  // Registered-output SRAM environment
  always @(posedge clk) begin
    if (bus.mem_wr) sram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= sram[bus.mem_addr];
  end

  always @(negedge clk) if (bus.mem_wr) wr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = wdata_valid always high, 1 = low on alternate cycles, 2 = random
  task automatic write_burst(input int a, input int len, input int mode);
    int beat = 0, cyc = 0, w0, exp_a;
    bit v;
    bus.cmd_valid = 1; bus.cmd_wr = 1;
    bus.cmd_addr = a[AW-1:0]; bus.cmd_len = len[AW-1:0];
    @(negedge clk);
    chk("wr_cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 0;
    w0 = wr_cnt;
    while (beat <= len && cyc < 100) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      exp_a = (a + beat) % DEPTH;
      bus.wdata_valid = v;
      bus.wdata = wbuf[beat];
      @(negedge clk);
      chk("wr_busy", bus.busy, 1);
      chk("wr_cmd_blocked", bus.cmd_ready, 0);
      chk("wr_wdata_ready", bus.wdata_ready, 1);
      chk("wr_mem_wr", bus.mem_wr, v);
      chk("wr_mem_addr", bus.mem_addr, exp_a);
      if (v) chk("wr_mem_din", bus.mem_din, wbuf[beat]);
      tick();
      if (v) begin
        ref_mem[exp_a] = wbuf[beat];
        beat++;
      end
      cyc++;
    end
    bus.wdata_valid = 0;
    if (beat <= len) chk("wr_timeout", 0, 1);
    @(negedge clk);
    chk("wr_end_busy", bus.busy, 0);
    chk("wr_end_cmd_ready", bus.cmd_ready, 1);
    chk("wr_pulse_count", wr_cnt - w0, len + 1);
    chk("wr_end_addr_hold", bus.mem_addr, (a + len) % DEPTH);
    tick();
  endtask

  // mode: 0 = rdata_ready immediate, 1 = random stall 0..3, >=2 = stall that many cycles
  task automatic read_burst(input int a, input int len, input int mode);
    int k, s, exp_a;
    bus.cmd_valid = 1; bus.cmd_wr = 0;
    bus.cmd_addr = a[AW-1:0]; bus.cmd_len = len[AW-1:0];
    bus.rdata_ready = 0;
    @(negedge clk);
    chk("rd_cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 0;
    for (int b = 0; b <= len; b++) begin
      exp_a = (a + b) % DEPTH;
      k = 1;
      @(negedge clk);
      while (!bus.rdata_valid && k < 20) begin
        chk("rd_no_write", bus.mem_wr, 0);
        k++;
        @(negedge clk);
      end
      chk("rd_latency", k, 3);
      chk("rd_data", bus.rdata, ref_mem[exp_a]);
      s = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(0, 3)) : mode;
      repeat (s) begin
        tick();
        @(negedge clk);
        chk("rd_stall_valid", bus.rdata_valid, 1);
        chk("rd_stall_data", bus.rdata, ref_mem[exp_a]);
        chk("rd_stall_addr", bus.mem_addr, exp_a);
        chk("rd_stall_no_wr", bus.mem_wr, 0);
      end
      bus.rdata_ready = 1;
      tick();
      bus.rdata_ready = 0;
    end
    @(negedge clk);
    chk("rd_end_busy", bus.busy, 0);
    chk("rd_end_cmd_ready", bus.cmd_ready, 1);
    tick();
  endtask

  initial begin
    int a, len;
    rst = 1;
    bus.cmd_valid = 0; bus.cmd_wr = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdata_valid = 0; bus.wdata = '0; bus.rdata_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = DW'($urandom);
      ref_mem[i] = sram[i];
    end

    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdata_valid", bus.rdata_valid, 0);
    chk("rst_wdata_ready", bus.wdata_ready, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_rdata", bus.rdata, 0);
    tick();

    wbuf[0] = 4'hA;
    write_burst(3, 0, 0);
    read_burst(3, 0, 0);

    for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
    write_burst(14, 3, 0);
    read_burst(14, 3, 0);

    read_burst(5, 1, 5);

    for (int i = 0; i < 3; i++) wbuf[i] = DW'($urandom);
    write_burst(8, 2, 1);

    // Reset two beats into a four-beat write
    for (int i = 0; i < 4; i++) wbuf[i] = ~ref_mem[i];
    bus.cmd_valid = 1; bus.cmd_wr = 1; bus.cmd_addr = '0; bus.cmd_len = 4'd3;
    tick();
    bus.cmd_valid = 0;
    for (int i = 0; i < 2; i++) begin
      bus.wdata_valid = 1; bus.wdata = wbuf[i];
      tick();
      ref_mem[i] = wbuf[i];
    end
    bus.wdata = wbuf[2];
    rst = 1;
    @(negedge clk);
    chk("midrst_mem_wr", bus.mem_wr, 0);
    chk("midrst_wdata_ready", bus.wdata_ready, 0);
    chk("midrst_cmd_ready", bus.cmd_ready, 0);
    chk("midrst_rdata_valid", bus.rdata_valid, 0);
    tick();
    rst = 0;
    bus.wdata_valid = 0;
    @(negedge clk);
    chk("midrst_idle_ready", bus.cmd_ready, 1);
    chk("midrst_idle_busy", bus.busy, 0);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    tick();
    read_burst(0, 3, 0);

    for (int n = 0; n < 12; n++) begin
      a = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) wbuf[i] = DW'($urandom);
        write_burst(a, len, int'($urandom_range(0, 2)));
      end else begin
        read_burst(a, len, int'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
